pc_branch_ctrl: RTL and testbench
=================================

Name: pc_branch_ctrl

Overview:
- Program-flow stage directly downstream of the ALU in the 9-bit-ISA core.
- Latches the ALU Zero/Negative flags on compare instructions and evaluates branch conditions against those stored flags.
- Resolves branch targets through a small writable target LUT and owns the program counter.
- Sequences the core through idle / run / halted, with the Start/Done handshake to the testbench.

Parameters:
- PC_W, 10, program counter width; instruction ROM depth is 2**PC_W.
- LUT_AW, 4, branch-target LUT address width; LUT has 2**LUT_AW entries of PC_W bits.
- START_PC, 0, PC value loaded on every Start.

Ports:
- Clk  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  pulse: begin or restart program execution.
- Stall  input  1  hold PC and flags this cycle (multi-cycle data memory access).
- FlagWrite  input  1  current instruction is CMP; capture ZeroIn/NegativeIn.
- ZeroIn  input  1  ALU Zero flag.
- NegativeIn  input  1  ALU Negative flag.
- BranchEn  input  1  current instruction is a branch.
- BranchCond  input  2  00 always, 01 EQ (Z=1), 10 LT (N=1), 11 GE (N=0).
- TargetIdx  input  LUT_AW  branch-target LUT index from instruction field.
- HaltReq  input  1  current instruction is HALT.
- LutWe  input  1  LUT write strobe.
- LutAddr  input  LUT_AW  LUT write address.
- LutData  input  PC_W  LUT write data.
- ProgCtr  output  PC_W  address of the current instruction.
- ZeroFlag  output  1  stored Zero flag.
- NegFlag  output  1  stored Negative flag.
- BranchTaken  output  1  combinational: branch in the current cycle is taken.
- Busy  output  1  state is RUN.
- Done  output  1  state is HALTED.

Behaviour:
- Reset (asynchronous, Reset=0):
  - state IDLE, ProgCtr=0, ZeroFlag=0, NegFlag=0, Busy=0, Done=0.
  - All LUT entries cleared to 0.
  - BranchTaken=0 while not in RUN.
  - Reset asserted mid-program aborts immediately; no partial state survives.
- States:
  - IDLE: Start -> RUN with ProgCtr<=START_PC.
  - RUN: HaltReq and not Stall -> HALTED. ProgCtr holds the HALT address.
  - HALTED: Done=1. Start -> RUN with ProgCtr<=START_PC, flags cleared, Done=0 on the next edge.
- Start while in RUN is ignored.
- RUN cycle priority (one instruction per cycle, single-cycle latency):
  1. Stall: PC, flags and state all hold; HaltReq, BranchEn and FlagWrite are ignored this cycle. The upstream stage re-presents the same instruction.
  2. HaltReq: go to HALTED; PC unchanged.
  3. BranchEn and condition true: ProgCtr<=LUT[TargetIdx].
  4. Otherwise: ProgCtr<=ProgCtr+1, modulo 2**PC_W (wraps from all-ones to 0, no error).
- Branch condition uses the stored flags (ZeroFlag/NegFlag), never ZeroIn/NegativeIn directly.
- If FlagWrite and BranchEn are both high in the same cycle, the condition uses the old flags; the new flags are captured at the edge.
- Flag capture:
  - In RUN, FlagWrite and not Stall -> ZeroFlag<=ZeroIn, NegFlag<=NegativeIn.
  - Flags persist until the next capture or Start.
- BranchTaken = Busy & BranchEn & condition & ~Stall & ~HaltReq.
- LUT writes:
  - Accepted only in IDLE or HALTED; LutWe in RUN is ignored.
  - A write and a Start in the same cycle: the write completes, so a branch in the first RUN cycle sees the new value.
- In IDLE and HALTED, ProgCtr holds.

Decomposition:
- Shared package (the existing definitions package):
  - branch condition enum (BR_ALWAYS, BR_EQ, BR_LT, BR_GE).
  - state enum (ST_IDLE, ST_RUN, ST_HALTED).
  - PC_W and LUT_AW defaults.
- One sub-module, branch_target_lut:
  - synchronous write, asynchronous read, async active-low clear.
  - Instantiated once.
- FSM, PC register and flag registers live in the top module.

Test Plan:
- Reset then Start: ProgCtr 0,1,2,3 on successive edges; Busy=1, Done=0.
- LUT[3]=0x040 written in IDLE. Run, then CMP with ZeroIn=1, next cycle BranchEn, BranchCond=01, TargetIdx=3 -> BranchTaken=1, ProgCtr=0x040. Repeat with ZeroIn=0 -> ProgCtr increments.
- FlagWrite (NegativeIn=1) and BranchEn with LT in the same cycle, old NegFlag=0 -> not taken. Next cycle LT branch -> taken.
- Stall held 3 cycles at ProgCtr=5 with BranchEn high -> ProgCtr stays 5 and flags unchanged. Release -> 6.
- Wrap and halt: start at PC 0x3FF -> next PC 0x000. HaltReq at PC 0x010 -> Done=1 and ProgCtr=0x010 holds. Start -> ProgCtr=0, Done=0.
- Reset pulled low mid-run at ProgCtr=0x022 -> ProgCtr=0, flags 0 and state IDLE immediately (before the next edge). LutWe during RUN -> entry unchanged.

Source files
------------

// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the program-flow stage of the 9-bit-ISA core.
// Holds the branch-condition and sequencer state encodings, the default
// PC / LUT address widths, and the branch-condition evaluation helper.
package pc_branch_ctrl_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 4;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_EQ     = 2'b01,
    BR_LT     = 2'b10,
    BR_GE     = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  // Evaluates a branch condition against the stored Zero/Negative flags.
  function automatic logic br_cond_met(input br_cond_e cond,
                                       input logic     zero,
                                       input logic     neg);
    logic met;
    met = 1'b0;
    case (cond)
      BR_ALWAYS: met = 1'b1;
      BR_EQ:     met = zero;
      BR_LT:     met = neg;
      BR_GE:     met = ~neg;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_branch_target_lut.sv
// Branch-target lookup table: 2**AW entries of DW bits.
// Synchronous write, asynchronous (combinational) read, async active-low clear.
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low clear of every entry
//   i_we     - write strobe (already qualified by the caller)
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data for i_raddr
module branch_target_lut #(
  parameter int AW = 4,
  parameter int DW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program-flow stage downstream of the ALU: stores compare flags, resolves
// branches through a writable target LUT, owns the program counter and
// sequences IDLE -> RUN -> HALTED with the Start/Done handshake.
// Ports:
//   Clk, Reset (async active-low)
//   Start, Stall, HaltReq                  - sequencing controls
//   FlagWrite, ZeroIn, NegativeIn          - flag capture from the ALU
//   BranchEn, BranchCond, TargetIdx        - branch request
//   LutWe, LutAddr, LutData                - target LUT write port
//   ProgCtr, ZeroFlag, NegFlag             - architectural state
//   BranchTaken (combinational), Busy, Done
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              LUT_AW   = LUT_AW_DEF,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              FlagWrite,
  input  logic              ZeroIn,
  input  logic              NegativeIn,
  input  logic              BranchEn,
  input  logic [1:0]        BranchCond,
  input  logic [LUT_AW-1:0] TargetIdx,
  input  logic              HaltReq,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              ZeroFlag,
  output logic              NegFlag,
  output logic              BranchTaken,
  output logic              Busy,
  output logic              Done
);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_zero;
  logic            r_neg;

  logic            w_run;
  logic            w_cond;
  logic            w_taken;
  logic            w_lut_we;
  logic [PC_W-1:0] w_target;

  assign w_run    = (r_state == ST_RUN);
  // Condition always looks at the stored flags, so a CMP and a branch in the
  // same cycle branch on the previous compare result.
  assign w_cond   = br_cond_met(br_cond_e'(BranchCond), r_zero, r_neg);
  assign w_taken  = w_run & BranchEn & w_cond & ~Stall & ~HaltReq;
  // The table is frozen while a program runs.
  assign w_lut_we = LutWe & ~w_run;

  branch_target_lut #(
    .AW(LUT_AW),
    .DW(PC_W)
  ) u_lut (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_we    (w_lut_we),
    .i_waddr (LutAddr),
    .i_wdata (LutData),
    .i_raddr (TargetIdx),
    .o_rdata (w_target)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (Start) begin
            r_state <= ST_RUN;
            r_pc    <= START_PC;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
          end
        end
        ST_RUN: begin
          // A stalled cycle freezes everything; the instruction is re-presented.
          if (!Stall) begin
            if (HaltReq) begin
              r_state <= ST_HALTED;
            end else if (w_taken) begin
              r_pc <= w_target;
            end else begin
              r_pc <= r_pc + PC_W'(1);
            end
            if (FlagWrite) begin
              r_zero <= ZeroIn;
              r_neg  <= NegativeIn;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ProgCtr     = r_pc;
  assign ZeroFlag    = r_zero;
  assign NegFlag     = r_neg;
  assign BranchTaken = w_taken;
  assign Busy        = w_run;
  assign Done        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0, Stall = 1'b0, FlagWrite = 1'b0;
  logic       ZeroIn = 1'b0, NegativeIn = 1'b0, BranchEn = 1'b1;
  logic [1:0] BranchCond = 2'b00;
  logic [3:0] TargetIdx = 4'd0, LutAddr = 4'd0;
  logic       HaltReq = 1'b0, LutWe = 1'b0;
  logic [9:0] LutData = 10'd0;
  logic [9:0] ProgCtr;
  logic       ZeroFlag, NegFlag, BranchTaken, Busy, Done;

  pc_branch_ctrl #(.PC_W(10), .LUT_AW(4), .START_PC(10'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .FlagWrite(FlagWrite), .ZeroIn(ZeroIn), .NegativeIn(NegativeIn),
    .BranchEn(BranchEn), .BranchCond(BranchCond), .TargetIdx(TargetIdx),
    .HaltReq(HaltReq), .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
    .ProgCtr(ProgCtr), .ZeroFlag(ZeroFlag), .NegFlag(NegFlag),
    .BranchTaken(BranchTaken), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         id;
    logic       taken;
    logic [9:0] pc;
    logic       z, n, busy, done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_id  = 0;
  logic mon_active = 1'b0;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, id, act, exp);
    end
  endtask

  // One instruction cycle: drive inputs after the falling edge and queue the
  // hand-computed BranchTaken for this cycle plus the state after the edge.
  task automatic cyc(input logic st, input logic stl, input logic fw,
                     input logic zi, input logic ni, input logic be,
                     input logic [1:0] bc, input logic [3:0] ix,
                     input logic hr, input logic lwe, input logic [3:0] la,
                     input logic [9:0] ld, input logic e_tk,
                     input logic [9:0] e_pc, input logic e_z, input logic e_n,
                     input logic e_b, input logic e_d);
    exp_t e;
    @(negedge Clk);
    Start = st; Stall = stl; FlagWrite = fw; ZeroIn = zi; NegativeIn = ni;
    BranchEn = be; BranchCond = bc; TargetIdx = ix; HaltReq = hr;
    LutWe = lwe; LutAddr = la; LutData = ld;
    e.id = n_id; e.taken = e_tk; e.pc = e_pc; e.z = e_z; e.n = e_n;
    e.busy = e_b; e.done = e_d;
    n_id++;
    q.push_back(e);
  endtask

  // Monitor: BranchTaken is checked mid-cycle, registered state after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (q.size() > 0) begin
        mon_active = 1'b1;
        e = q.pop_front();
        chk("BranchTaken", e.id, int'(BranchTaken), int'(e.taken));
        @(posedge Clk);
        #1;
        chk("ProgCtr",  e.id, int'(ProgCtr),  int'(e.pc));
        chk("ZeroFlag", e.id, int'(ZeroFlag), int'(e.z));
        chk("NegFlag",  e.id, int'(NegFlag),  int'(e.n));
        chk("Busy",     e.id, int'(Busy),     int'(e.busy));
        chk("Done",     e.id, int'(Done),     int'(e.done));
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    int waited;
    // Reset state, BranchEn held high to show no branch outside RUN.
    #12;
    chk("rst_ProgCtr", -1, int'(ProgCtr), 0);
    chk("rst_flags",   -1, int'({ZeroFlag, NegFlag}), 0);
    chk("rst_BusyDone", -1, int'({Busy, Done}), 0);
    chk("rst_BranchTaken", -1, int'(BranchTaken), 0);
    @(negedge Clk);
    Reset = 1'b1;
    //   st stl fw zi ni be bc    ix     hr lwe la     ld       tk pc       z  n  b  d
    // LUT loads in IDLE; the last one coincides with Start.
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 1, 4'd3, 10'h040, 0, 10'h000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 1, 4'd1, 10'h3FF, 0, 10'h000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 1, 4'd2, 10'h010, 0, 10'h000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 1, 4'd5, 10'h005, 0, 10'h000, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 1, 4'd4, 10'h022, 0, 10'h000, 0, 0, 1, 0);
    // Sequential fetch.
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h001, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h002, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h003, 0, 0, 1, 0);
    // CMP Z=1, then BEQ -> LUT[3].
    cyc(0, 0, 1, 1, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h004, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'd3, 0, 0, 4'd0, 10'h000, 1, 10'h040, 1, 0, 1, 0);
    // CMP Z=0, then BEQ falls through.
    cyc(0, 0, 1, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h041, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'd3, 0, 0, 4'd0, 10'h000, 0, 10'h042, 0, 0, 1, 0);
    // CMP N=1 together with BLT: old N=0 decides. Next BLT is taken.
    cyc(0, 0, 1, 0, 1, 1, 2'b10, 4'd3, 0, 0, 4'd0, 10'h000, 0, 10'h043, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b10, 4'd3, 0, 0, 4'd0, 10'h000, 1, 10'h040, 0, 1, 1, 0);
    // BGE with N=1 is not taken.
    cyc(0, 0, 0, 0, 0, 1, 2'b11, 4'd3, 0, 0, 4'd0, 10'h000, 0, 10'h041, 0, 1, 1, 0);
    // Go to PC 5, then stall three cycles with branch/CMP/halt asserted.
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd5, 0, 0, 4'd0, 10'h000, 1, 10'h005, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 2'b00, 4'd3, 0, 0, 4'd0, 10'h000, 0, 10'h005, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 2'b00, 4'd3, 1, 0, 4'd0, 10'h000, 0, 10'h005, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 2'b00, 4'd3, 0, 0, 4'd0, 10'h000, 0, 10'h005, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h006, 0, 1, 1, 0);
    // LUT write during RUN is dropped: LUT[3] still 0x040.
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 1, 4'd3, 10'h155, 0, 10'h007, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd3, 0, 0, 4'd0, 10'h000, 1, 10'h040, 0, 1, 1, 0);
    // Wrap: jump to 0x3FF, next fetch is 0x000.
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd1, 0, 0, 4'd0, 10'h000, 1, 10'h3FF, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h000, 0, 1, 1, 0);
    // Halt at 0x010 (branch request alongside HALT is suppressed).
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd2, 0, 0, 4'd0, 10'h000, 1, 10'h010, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd3, 1, 0, 4'd0, 10'h000, 0, 10'h010, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd3, 0, 0, 4'd0, 10'h000, 0, 10'h010, 0, 1, 0, 1);
    // Restart from HALTED clears flags; Start in RUN is ignored.
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h000, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h001, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 1, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h002, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd4, 0, 0, 4'd0, 10'h000, 1, 10'h022, 1, 1, 1, 0);

    waited = 0;
    while ((q.size() != 0 || mon_active) && waited < 20) begin
      @(posedge Clk);
      waited++;
    end
    #2;
    // Asynchronous reset mid-run at 0x022 takes effect before any edge.
    @(negedge Clk);
    BranchEn = 1'b1; BranchCond = 2'b00; TargetIdx = 4'd4;
    Reset = 1'b0;
    #1;
    chk("arst_ProgCtr", -2, int'(ProgCtr), 0);
    chk("arst_flags",   -2, int'({ZeroFlag, NegFlag}), 0);
    chk("arst_BusyDone", -2, int'({Busy, Done}), 0);
    chk("arst_BranchTaken", -2, int'(BranchTaken), 0);
    @(negedge Clk);
    Reset = 1'b1;
    // LUT was cleared by reset: branch to LUT[4] now lands on 0.
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h000, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h001, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 4'd4, 0, 0, 4'd0, 10'h000, 1, 10'h000, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0, 4'd0, 10'h000, 0, 10'h001, 0, 0, 1, 0);

    waited = 0;
    while ((q.size() != 0 || mon_active) && waited < 20) begin
      @(posedge Clk);
      waited++;
    end
    #2;
    if (q.size() != 0 || mon_active) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
